// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter register and next-PC selection.
//
// Holds the PC, presents it to instruction memory with a valid/ready
// handshake and, on each accepted fetch, loads the next PC selected by
// the redirect controls (exception > misaligned JR > JR > J > branch > +4).
// A retired-instruction counter tracks the number of advances.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem_ready      instruction memory accepts pc this cycle
//   stall           hazard/multicycle hold, blocks advance
//   branch_taken    branch condition met
//   jump, jr        J/JAL and JR/JALR controls
//   exception       synchronous exception request
//   halt            stop fetching after the current instruction
//   branch_offset   sign-extended immediate, already shifted left by 2
//   jump_index      instr[25:0]
//   jr_target       register-file read value
//   pc, pc_plus4    current PC and pc + 4 (combinational)
//   pc_valid        pc is a valid fetch request
//   misalign_err    one-cycle pulse after a misaligned JR advance
//   halted          block is in the halted state
//   instr_count     number of advances since reset
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic        exception,
  input  logic        halt,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        misalign_err,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;
  logic        advance;
  logic        jr_misaligned;
  logic [31:0] jump_target;

  assign pc_plus4      = pc_q + 32'd4;
  assign advance       = valid_q & imem_ready & ~stall;
  assign jr_misaligned = jr & (jr_target[1:0] != 2'b00);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    state_d    = state_q;
    misalign_d = 1'b0;

    if (advance) begin
      count_d = count_q + 32'd1;
      if (exception) begin
        pc_d = EXC_VECTOR;
      end else if (jr_misaligned) begin
        pc_d       = EXC_VECTOR;
        misalign_d = 1'b1;
      end else if (jr) begin
        pc_d = jr_target;
      end else if (jump) begin
        pc_d = jump_target;
      end else if (branch_taken) begin
        pc_d = pc_plus4 + branch_offset;
      end else begin
        pc_d = pc_plus4;
      end
    end

    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (advance && halt) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StBoot;
    endcase

    // Outputs are registered, so decode them from the next state.
    valid_d  = (state_d == StRun);
    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      count_q    <= 32'd0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = valid_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic        exception;
  logic        halt;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        misalign_err;
  logic        halted;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  pc_next_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr           (jr),
    .exception    (exception),
    .halt         (halt),
    .branch_offset(branch_offset),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_valid     (pc_valid),
    .misalign_err (misalign_err),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    jump          = 1'b0;
    jr            = 1'b0;
    exception     = 1'b0;
    halt          = 1'b0;
    branch_offset = 32'h0;
    jump_index    = 26'h0;
    jr_target     = 32'h0;
  endtask

  // Drive a JR redirect for one advance.
  task automatic do_jr(input logic [31:0] tgt);
    clear_ctl();
    jr        = 1'b1;
    jr_target = tgt;
    step();
    clear_ctl();
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    clear_ctl();
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'h0, pc_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    check("rst_count", instr_count, 32'h0);

    rst_n = 1'b1;
    step();
    check("boot_valid", {31'h0, pc_valid}, 32'h1);
    check("boot_pc", pc, 32'h0);
    check("boot_count", instr_count, 32'h0);
    step();
    check("seq_pc4", pc, 32'h4);
    step();
    check("seq_pc8", pc, 32'h8);
    check("seq_count2", instr_count, 32'd2);
    check("seq_plus4", pc_plus4, 32'hC);

    do_jr(32'h10);
    check("jr_pc10", pc, 32'h10);
    branch_taken  = 1'b1;
    branch_offset = 32'h20;
    step();
    check("br_fwd", pc, 32'h34);
    do_jr(32'h40);
    branch_taken  = 1'b1;
    branch_offset = 32'hFFFF_FFF0;
    step();
    check("br_back", pc, 32'h34);

    do_jr(32'h1000_0008);
    jump       = 1'b1;
    jump_index = 26'h000_0040;
    step();
    check("jump", pc, 32'h1000_0100);
    check("count8", instr_count, 32'd8);

    clear_ctl();
    jump = 1'b1; branch_taken = 1'b1; branch_offset = 32'h40;
    jr = 1'b1; jr_target = 32'h200; jump_index = 26'h3;
    step();
    check("prio_jr", pc, 32'h200);
    exception = 1'b1;
    step();
    check("prio_exc", pc, 32'h180);
    check("prio_exc_mis", {31'h0, misalign_err}, 32'h0);

    do_jr(32'h202);
    check("mis_pc", pc, 32'h180);
    check("mis_pulse", {31'h0, misalign_err}, 32'h1);
    step();
    check("mis_clear", {31'h0, misalign_err}, 32'h0);
    check("mis_next_pc", pc, 32'h184);

    do_jr(32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    step();
    check("wrap_pc", pc, 32'h0);
    check("count14", instr_count, 32'd14);

    stall = 1'b1;
    jump  = 1'b1;
    jump_index = 26'h3FF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h0);
      check("stall_count", instr_count, 32'd14);
    end
    clear_ctl();
    imem_ready = 1'b0;
    exception  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nrdy_pc", pc, 32'h0);
      check("nrdy_count", instr_count, 32'd14);
    end
    clear_ctl();
    imem_ready = 1'b1;
    step();
    step();
    check("pre_halt_pc", pc, 32'h8);
    halt = 1'b1;
    step();
    clear_ctl();
    check("halt_pc", pc, 32'hC);
    check("halt_valid", {31'h0, pc_valid}, 32'h0);
    check("halt_flag", {31'h0, halted}, 32'h1);
    check("halt_count", instr_count, 32'd17);
    for (int i = 0; i < 3; i++) begin
      step();
      check("halted_pc", pc, 32'hC);
      check("halted_flag", {31'h0, halted}, 32'h1);
      check("halted_valid", {31'h0, pc_valid}, 32'h0);
    end

    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_count", instr_count, 32'h0);
    check("arst_halted", {31'h0, halted}, 32'h0);
    step();
    rst_n = 1'b1;
    clear_ctl();
    step();
    check("rerun_valid", {31'h0, pc_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
